// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with a per-register busy (scoreboard) bit.
// Reads are combinational. Two write ports: a write stores data and clears busy.
// An allocation port marks a register as having a pending producer.
// Optional feature: define REGFILE_SB_BYPASS_EN to forward same-cycle write
// data to the read ports.
module regfile_sb #(
  parameter  int LENGTH   = 8,
  parameter  int NREGS    = 8,
  parameter  int NRD      = 2,
  parameter  int ZERO_REG = 1,
  localparam int SEL_BITS = $clog2(NREGS)
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic [NRD*SEL_BITS-1:0] addr_r,
  output logic [NRD*LENGTH-1:0]   data_r,
  output logic [NRD-1:0]          busy_r,
  input  logic [1:0]              wr,
  input  logic [2*SEL_BITS-1:0]   addr_d,
  input  logic [2*LENGTH-1:0]     data_in,
  input  logic                    alloc,
  input  logic [SEL_BITS-1:0]     addr_alloc,
  output logic                    alloc_ok
);

  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [LENGTH-1:0]   regs [NREGS];
  logic [NREGS-1:0]    busy;

  logic [SEL_BITS-1:0] wa0, wa1;
  logic [LENGTH-1:0]   wd0, wd1;
  logic                we0, we1;

  assign wa0 = addr_d[0 +: SEL_BITS];
  assign wa1 = addr_d[SEL_BITS +: SEL_BITS];
  assign wd0 = data_in[0 +: LENGTH];
  assign wd1 = data_in[LENGTH +: LENGTH];

  // Writes to the hard-wired zero register are discarded at the source.
  assign we0 = wr[0] && !(HAS_ZERO && (wa0 == '0));
  assign we1 = wr[1] && !(HAS_ZERO && (wa1 == '0));

  // Allocation looks only at stored busy state, never at same-cycle writes.
  assign alloc_ok = alloc && !reset && !busy[addr_alloc] &&
                    !(HAS_ZERO && (addr_alloc == '0));

  // Register and busy state update.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      // NOTE: the storage array is cleared on reset because reads of reset
      // state must return 0; a loop of non-blocking stores does this per entry.
      for (int r = 0; r < NREGS; r++) begin
        regs[r] <= '0;
      end
      busy <= '0;
    end else begin
      // NOTE: non-blocking assignments take the last one issued, so the order
      // below encodes priority: port 1 beats port 0, and an allocation sets
      // busy even when a write to the same register clears it this cycle.
      if (we0) begin
        regs[wa0] <= wd0;
        busy[wa0] <= 1'b0;
      end
      if (we1) begin
        regs[wa1] <= wd1;
        busy[wa1] <= 1'b0;
      end
      if (alloc_ok) begin
        busy[addr_alloc] <= 1'b1;
      end
    end
  end

  for (genvar i = 0; i < NRD; i++) begin : g_rd
    logic [SEL_BITS-1:0] ra;
    logic [LENGTH-1:0]   rd;
    logic                rb;

    assign ra = addr_r[i*SEL_BITS +: SEL_BITS];

    // Combinational read of data and busy for one port, with optional forwarding.
    always_comb begin
      // NOTE: every output of this block gets a value first so no path can
      // leave it unassigned and infer a latch.
      rd = regs[ra];
      rb = busy[ra];
`ifdef REGFILE_SB_BYPASS_EN
      if (!reset && we0 && (wa0 == ra)) begin
        rd = wd0;
        rb = 1'b0;
      end
      if (!reset && we1 && (wa1 == ra)) begin
        rd = wd1;
        rb = 1'b0;
      end
`else
      // Reads see stored state only; written values appear after the edge.
`endif
      if (HAS_ZERO && (ra == '0)) begin
        rd = '0;
        rb = 1'b0;
      end
    end

    assign data_r[i*LENGTH +: LENGTH] = rd;
    assign busy_r[i]                  = rb;
  end

endmodule

// File: doc/regfile_sb.md
REGFILE_SB -- requirements
Module: regfile_sb

Interface
REQ-001 Parameter LENGTH, default 8: data width in bits, legal range 1..64.
REQ-002 Parameter NREGS, default 8: register count, power of two, legal range 2..64; SEL_BITS = $clog2(NREGS).
REQ-003 Parameter NRD, default 2: number of read ports, legal range 1..4.
REQ-004 Parameter ZERO_REG, default 1: when 1, register 0 reads as 0, is never written and is never busy.
REQ-005 clk  in  1  single clock; all state updates on the rising edge.
REQ-006 reset  in  1  asynchronous, active-high reset.
REQ-007 addr_r  in  NRD*SEL_BITS  read addresses; port i uses bits [i*SEL_BITS +: SEL_BITS].
REQ-008 data_r  out  NRD*LENGTH  read data; port i uses bits [i*LENGTH +: LENGTH].
REQ-009 busy_r  out  NRD  port i: the addressed register has a pending producer.
REQ-010 wr  in  2  write enable for write ports 0 and 1.
REQ-011 addr_d  in  2*SEL_BITS  write addresses for ports 0 and 1.
REQ-012 data_in  in  2*LENGTH  write data for ports 0 and 1.
REQ-013 alloc  in  1  request to mark register addr_alloc as busy (producer issued).
REQ-014 addr_alloc  in  SEL_BITS  register to allocate.
REQ-015 alloc_ok  out  1  allocation is accepted this cycle.

Function
REQ-016 Reads are combinational: data_r[i] = reg[addr_r[i]] and busy_r[i] = busy[addr_r[i]], with no clock latency.
REQ-017 On a rising edge with wr[p]=1, reg[addr_d[p]] takes data_in[p] and busy[addr_d[p]] clears.
REQ-018 When both write ports target the same address in one cycle, port 1 data is written and port 0 is dropped.
REQ-019 When ZERO_REG=1, writes and allocations to address 0 are ignored, and data_r and busy_r for address 0 are constant 0.
REQ-020 alloc_ok = alloc AND NOT busy[addr_alloc] AND NOT (ZERO_REG=1 AND addr_alloc=0); an accepted alloc sets busy[addr_alloc] on the next rising edge.
REQ-021 Allocation of a register that is already busy is rejected with alloc_ok=0 (WAW hazard), and state is unchanged.
REQ-022 When an accepted alloc and a write target the same register in one cycle, the register takes the written data and busy ends the cycle set (the new producer wins).
REQ-023 alloc_ok does not consider same-cycle writes; a register freed by a write this cycle is allocatable from the next cycle.
REQ-024 Unwritten registers hold their value; state changes only through write, alloc or reset.

Reset
REQ-025 While reset=1, asynchronously and regardless of clk: all registers are 0 and all busy bits are 0.
REQ-026 During reset, data_r=0, busy_r=0 and alloc_ok=0 for all ports.
REQ-027 When reset is asserted in the same cycle as a write or alloc, reset wins, and no update survives the deassertion.

Configuration
REQ-028 Macro REGFILE_SB_BYPASS_EN, when defined, adds write-to-read forwarding: a read address matching an active write this cycle returns that write's data_in (port 1 when both ports match) and reports busy_r=0.
REQ-029 When REGFILE_SB_BYPASS_EN is defined and an accepted alloc targets the same register in that cycle, the read still reports busy_r=0 this cycle, and busy is seen from the next cycle.
REQ-030 Without REGFILE_SB_BYPASS_EN, reads return stored state only, so written data and busy clear are visible from the cycle after the edge.

Verification
REQ-031 Scenario: assert reset mid-cycle after writing 0xAA to r3 -> data_r and busy_r are 0 immediately, without waiting for a clock edge.
REQ-032 Scenario: wr[0]=1, addr_d[0]=3, data 0xAA for one cycle, then addr_r[0]=3 -> data_r[0]=0xAA; with the bypass macro, 0xAA appears in the write cycle itself.
REQ-033 Scenario: both ports write r5, port 0 with 0x11 and port 1 with 0x22 -> r5 reads 0x22.
REQ-034 Scenario: alloc r2 -> alloc_ok=1 and busy_r=1 next cycle; a second alloc of r2 -> alloc_ok=0; a write of 0x7F to r2 -> busy clears and r2 reads 0x7F.
REQ-035 Scenario: alloc r4 together with a write of 0x33 to r4 -> r4 reads 0x33 and busy_r=1 afterwards.
REQ-036 Scenario: with ZERO_REG=1, write 0xFF to r0 and alloc r0 -> r0 reads 0, alloc_ok=0 and busy_r=0.
